// File: rtl/unary_mac.sv
// unary_mac: unsigned multiply-accumulate that emits each product w*x as a
// burst of w*x consecutive single-cycle pulses. A binary accumulator counts
// those pulses across a dot-product sequence. When the pair flagged in_last
// has finished, acc_valid strobes for one cycle.
//
// Handshake: a pair on {w, x, in_last} is consumed on a rising edge where
// in_valid && in_ready. in_ready is high only in IDLE while abort is low, and
// it does not depend on in_valid. While in_ready is low, in_valid is ignored
// and the presented pair stays with the producer.
module unary_mac #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] w,
    input  logic [WIDTH-1:0] x,
    input  logic             in_last,
    output logic             out_pulse,
    output logic [ACC_W-1:0] acc,
    output logic             acc_valid,
    output logic             overflow,
    output logic             busy,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_next_state;

    // top counts the remaining rows (w); bot counts the pulses left in the current row (x).
    logic [WIDTH-1:0] r_top;
    logic [WIDTH-1:0] r_bot;
    logic [WIDTH-1:0] r_x0;
    logic             r_last;

    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    // Set when the next accepted pair opens a new sequence and must clear acc.
    logic             r_fresh;

    logic             w_accept;
    logic             w_zero_pair;
    logic             w_row_end;
    logic             w_prod_end;

    assign w_accept    = in_valid && in_ready;
    assign w_zero_pair = (w == '0) || (x == '0);
    assign w_row_end   = (r_bot == CNT_ONE);
    assign w_prod_end  = w_row_end && (r_top == CNT_ONE);

    // State register; abort is folded into the next-state logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: abort wins over everything else.
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_zero_pair) begin
                            w_next_state = in_last ? S_DONE : S_IDLE;
                        end else begin
                            w_next_state = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_prod_end) begin
                        w_next_state = r_last ? S_DONE : S_IDLE;
                    end
                end
                S_DONE: begin
                    w_next_state = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // State-decoded outputs; every RUN cycle is one pulse of the product.
    always_comb begin
        in_ready  = (r_state == S_IDLE) && !abort;
        out_pulse = (r_state == S_RUN);
        acc_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
        o_state   = r_state;
    end

    // Product counters: load on accept; step one pulse per RUN cycle, reloading the row from x0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_top  <= '0;
            r_bot  <= '0;
            r_x0   <= '0;
            r_last <= 1'b0;
        end else if (abort) begin
            r_top  <= '0;
            r_bot  <= '0;
            r_x0   <= '0;
            r_last <= 1'b0;
        end else if (w_accept) begin
            r_top  <= w;
            r_bot  <= x;
            r_x0   <= x;
            r_last <= in_last;
        end else if (r_state == S_RUN) begin
            if (!w_row_end) begin
                r_bot <= r_bot - CNT_ONE;
            end else if (!w_prod_end) begin
                r_bot <= r_x0;
                r_top <= r_top - CNT_ONE;
            end
        end
    end

    // Saturating pulse accumulator with a sticky overflow flag.
    // It is cleared by the first accept of each new sequence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_fresh <= 1'b1;
        end else if (abort) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_fresh <= 1'b1;
        end else if (w_accept) begin
            if (r_fresh) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end
            r_fresh <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (r_acc == ACC_MAX) begin
                r_ovf <= 1'b1;
            end else begin
                r_acc <= r_acc + 1'b1;
            end
        end else if (r_state == S_DONE) begin
            r_fresh <= 1'b1;
        end
    end

    assign acc      = r_acc;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_unary_mac.sv
// Directed bench for unary_mac. Pair timing, pulse counts and accumulator values come
// from a hand-computed vector table. A scoreboard queue holds every acc value expected
// at an acc_valid strobe. Abort, mid-run reset, saturation and streaming are
// hand-written sequences. A second instance with ACC_W=8 shares all inputs and is
// used to observe saturation.
module tb_unary_mac;

  logic       clk;
  logic       reset_n;
  logic       abort;
  logic       in_valid;
  logic [3:0] w_in;
  logic [3:0] x_in;
  logic       in_last;

  logic        in_ready;
  logic        out_pulse;
  logic [15:0] acc;
  logic        acc_valid;
  logic        overflow;
  logic        busy;
  logic [1:0]  o_state;

  logic       sat_in_ready;
  logic       sat_out_pulse;
  logic [7:0] sat_acc;
  logic       sat_acc_valid;
  logic       sat_overflow;
  logic       sat_busy;
  logic [1:0] sat_o_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  logic [7:0] sat_acc_v;
  logic       sat_ovf_v;

  typedef struct {
    logic [3:0] w;
    logic [3:0] x;
    logic       last;
    int         exp_p;
    int         exp_acc;
  } vec_t;

  vec_t vecs[8];

  unary_mac dut (
    .clk(clk), .reset_n(reset_n), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready), .w(w_in), .x(x_in), .in_last(in_last),
    .out_pulse(out_pulse), .acc(acc), .acc_valid(acc_valid),
    .overflow(overflow), .busy(busy), .o_state(o_state)
  );

  unary_mac #(.WIDTH(4), .ACC_W(8)) dut_sat (
    .clk(clk), .reset_n(reset_n), .abort(abort), .in_valid(in_valid),
    .in_ready(sat_in_ready), .w(w_in), .x(x_in), .in_last(in_last),
    .out_pulse(sat_out_pulse), .acc(sat_acc), .acc_valid(sat_acc_valid),
    .overflow(sat_overflow), .busy(sat_busy), .o_state(sat_o_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // scoreboard: every acc_valid strobe must match the next queued value
  always @(negedge clk) begin
    if (reset_n && acc_valid) begin
      check("acc_valid expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) check("acc at acc_valid", {16'd0, acc}, exp_q.pop_front());
    end
  end

  // driver: offer one pair, then follow it until in_ready returns
  task automatic run_pair(input logic [3:0] pw, input logic [3:0] px, input logic pl,
                          input int exp_p, input int exp_acc, input string tag);
    int n;
    int pulses;
    int win;
    int ready_n;
    int seen_valid;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready before accept"}, {31'd0, in_ready}, 32'd1);
    w_in = pw;
    x_in = px;
    in_last = pl;
    in_valid = 1'b1;
    if (pl) exp_q.push_back(exp_acc);
    @(negedge clk);
    in_valid = 1'b0;
    w_in = 4'($urandom_range(0, 15));
    x_in = 4'($urandom_range(0, 15));
    in_last = 1'($urandom_range(0, 1));
    n = 1;
    pulses = 0;
    win = 0;
    ready_n = 0;
    seen_valid = 0;
    while (n <= 400) begin
      if (out_pulse) begin
        pulses++;
        if (n <= exp_p) win++;
      end
      if (acc_valid) begin
        seen_valid = 1;
        sat_acc_v = sat_acc;
        sat_ovf_v = sat_overflow;
      end
      if (in_ready) begin
        ready_n = n;
        break;
      end
      @(negedge clk);
      n++;
    end
    check({tag, " pulse count"}, pulses, exp_p);
    check({tag, " pulses consecutive from T+1"}, win, exp_p);
    check({tag, " in_ready return cycle"}, ready_n, exp_p + 1 + int'(pl));
    check({tag, " acc_valid seen"}, seen_valid, int'(pl));
    check({tag, " acc after pair"}, {16'd0, acc}, exp_acc);
    check({tag, " overflow"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    int pulses;
    int k;
    int got;
    int took;
    logic [3:0] sw[4];
    logic [3:0] sx[4];
    logic       sl[4];

    // w, x, last, pulses, acc when in_ready returns
    vecs[0] = '{4'd3,  4'd4,  1'b1, 12,  12};
    vecs[1] = '{4'd2,  4'd5,  1'b0, 10,  10};
    vecs[2] = '{4'd0,  4'd7,  1'b0, 0,   10};
    vecs[3] = '{4'd1,  4'd1,  1'b1, 1,   11};
    vecs[4] = '{4'd15, 4'd15, 1'b1, 225, 225};
    vecs[5] = '{4'd5,  4'd0,  1'b1, 0,   0};
    vecs[6] = '{4'd1,  4'd2,  1'b0, 2,   2};
    vecs[7] = '{4'd3,  4'd1,  1'b1, 3,   5};

    reset_n = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    w_in = '0;
    x_in = '0;
    in_last = 1'b0;
    sat_acc_v = '0;
    sat_ovf_v = 1'b0;

    // reset values
    #3;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_pulse", {31'd0, out_pulse}, 32'd0);
    check("reset acc", {16'd0, acc}, 32'd0);
    check("reset acc_valid", {31'd0, acc_valid}, 32'd0);
    check("reset overflow", {31'd0, overflow}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset state", {30'd0, o_state}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // table-driven pairs
    for (int i = 0; i < 8; i++) begin
      run_pair(vecs[i].w, vecs[i].x, vecs[i].last, vecs[i].exp_p, vecs[i].exp_acc,
               $sformatf("vec%0d", i));
    end

    // saturation: 3 x (15,15) = 675 pulses; the ACC_W=8 copy pins at 255
    run_pair(4'd15, 4'd15, 1'b0, 225, 225, "sat0");
    run_pair(4'd15, 4'd15, 1'b0, 225, 450, "sat1");
    run_pair(4'd15, 4'd15, 1'b1, 225, 675, "sat2");
    check("sat acc at acc_valid", {24'd0, sat_acc_v}, 32'd255);
    check("sat overflow at acc_valid", {31'd0, sat_ovf_v}, 32'd1);
    check("sat acc held in IDLE", {24'd0, sat_acc}, 32'd255);
    check("sat overflow held in IDLE", {31'd0, sat_overflow}, 32'd1);
    run_pair(4'd1, 4'd1, 1'b1, 1, 1, "post_sat");
    check("sat acc new sequence", {24'd0, sat_acc}, 32'd1);
    check("sat overflow cleared", {31'd0, sat_overflow}, 32'd0);

    // abort after 5 pulses of (4,4)
    w_in = 4'd4;
    x_in = 4'd4;
    in_last = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      if (out_pulse) pulses++;
      if (i < 5) @(negedge clk);
    end
    check("abort pulses before abort", pulses, 5);
    abort = 1'b1;
    #1;
    check("abort in_ready low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort out_pulse", {31'd0, out_pulse}, 32'd0);
    check("abort acc", {16'd0, acc}, 32'd0);
    check("abort acc_valid", {31'd0, acc_valid}, 32'd0);
    check("abort overflow", {31'd0, overflow}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort stays idle", {31'd0, in_ready}, 32'd1);
    run_pair(4'd2, 4'd2, 1'b1, 4, 4, "post_abort");

    // asynchronous reset in the middle of a product
    w_in = 4'd4;
    x_in = 4'd4;
    in_last = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async reset out_pulse", {31'd0, out_pulse}, 32'd0);
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset acc", {16'd0, acc}, 32'd0);
    check("async reset in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    run_pair(4'd1, 4'd3, 1'b1, 3, 3, "post_reset");

    // in_valid held high for a stream of 4 pairs: 6 + 0 + 5 + 9 = 20 pulses
    sw = '{4'd2, 4'd0, 4'd1, 4'd3};
    sx = '{4'd3, 4'd4, 4'd5, 4'd3};
    sl = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_q.push_back(32'd20);
    k = 0;
    got = 0;
    took = 0;
    pulses = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (out_pulse) pulses++;
      if (acc_valid) begin
        got = 1;
        break;
      end
      if (took != 0) k++;
      if (k < 4) begin
        w_in = sw[k];
        x_in = sx[k];
        in_last = sl[k];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      took = ((k < 4) && in_ready) ? 1 : 0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stream acc_valid seen", got, 1);
    check("stream total pulses", pulses, 20);
    check("stream pairs consumed", k, 4);
    check("stream acc", {16'd0, acc}, 32'd20);
    @(negedge clk);
    check("stream idle after done", {31'd0, in_ready}, 32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
